// File: rtl/div_unit_pkg.sv
// Shared definitions for the Execute-stage divider: state encoding and default width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DZERO = 2'b01,
    BUSY  = 2'b10,
    DONE  = 2'b11
  } divState_t;

endpackage

// File: rtl/div_unit_if.sv
// Pipeline <-> divider handshake: operands and control in, result/ready/stall out.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall;

  // Execute stage / hazard unit side.
  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall
  );

  // Divider side.
  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall
  );

endinterface

// File: rtl/div_unit_sign_fix.sv
// Conditional two's-complement negate: used both for operand magnitude and result sign fix-up.
module div_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] dataOut
);

  assign dataOut = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider; result = {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  divState_t          stateReg, stateNext;
  logic [2*WIDTH:0]   workReg, workNext;
  logic [WIDTH-1:0]   divisorReg;
  logic [CNT_W-1:0]   cntReg;
  logic               negQReg, negRReg;
  logic [2*WIDTH-1:0] resultReg;
  logic               readyInt;
  logic               divZero;
  logic               lastIter;
  logic [WIDTH+1:0]   trial;

  // Lanes 0/1: dividend/divisor magnitude; lanes 2/3: quotient/remainder sign fix-up.
  logic [WIDTH-1:0] fixIn  [4];
  logic             fixNeg [4];
  logic [WIDTH-1:0] fixOut [4];

  assign divZero  = (bus.opdata2 == '0);
  assign lastIter = (cntReg == CNT_W'(WIDTH - 1));

  assign fixIn[0]  = bus.opdata1;
  assign fixNeg[0] = bus.signed_div & bus.opdata1[WIDTH-1];
  assign fixIn[1]  = bus.opdata2;
  assign fixNeg[1] = bus.signed_div & bus.opdata2[WIDTH-1];
  assign fixIn[2]  = workNext[WIDTH-1:0];
  assign fixNeg[2] = negQReg;
  assign fixIn[3]  = workNext[2*WIDTH-1:WIDTH];
  assign fixNeg[3] = negRReg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gSignFix
      div_unit_sign_fix #(.WIDTH(WIDTH)) uFix (
        .value  (fixIn[gi]),
        .negate (fixNeg[gi]),
        .dataOut(fixOut[gi])
      );
    end
  endgenerate

  // Trial subtract on the partial remainder plus the next dividend bit shifted in.
  assign trial = workReg[2*WIDTH:WIDTH-1] - {2'b00, divisorReg};

  // One restoring step: keep the difference and shift in 1, or plain shift in 0.
  always_comb begin
    workNext = {workReg[2*WIDTH-1:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      workNext = {trial[WIDTH:0], workReg[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic; annul overrides every transition.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (bus.start) stateNext = divZero ? DZERO : BUSY;
      DZERO:   stateNext = DONE;
      BUSY:    if (lastIter) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.annul) stateNext = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Datapath: operand latch, iteration, and result capture on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      workReg    <= '0;
      divisorReg <= '0;
      cntReg     <= '0;
      negQReg    <= 1'b0;
      negRReg    <= 1'b0;
      resultReg  <= '0;
    end else if (bus.annul) begin
      workReg    <= '0;
      divisorReg <= '0;
      cntReg     <= '0;
      negQReg    <= 1'b0;
      negRReg    <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            cntReg  <= '0;
            negQReg <= fixNeg[0] ^ fixNeg[1];
            negRReg <= fixNeg[0];
            if (divZero) begin
              // Raw dividend is parked here so DZERO can echo it back.
              workReg    <= {{(WIDTH+1){1'b0}}, bus.opdata1};
              divisorReg <= '0;
            end else begin
              workReg    <= {{(WIDTH+1){1'b0}}, fixOut[0]};
              divisorReg <= fixOut[1];
            end
          end
        end
        BUSY: begin
          workReg <= workNext;
          cntReg  <= cntReg + CNT_W'(1);
          if (lastIter) resultReg <= {fixOut[3], fixOut[2]};
        end
        DZERO: resultReg <= {workReg[WIDTH-1:0], {WIDTH{1'b1}}};
        default: ;
      endcase
    end
  end

  assign readyInt   = (stateReg == DONE);
  assign bus.ready  = readyInt;
  assign bus.result = resultReg;
  assign bus.stall  = bus.start & ~readyInt;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a per-cycle arithmetic reference model.
module tb_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int readyCount = 0;
  bit chkEn = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference result from plain arithmetic; 64-bit signed math avoids the INT_MIN/-1 trap.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Model: operation accepted -> ready a fixed number of cycles later, result held otherwise.
  bit          mBusy  = 1'b0;
  int          mCount = 0;
  logic [63:0] mExp   = '0;
  logic [63:0] mLast  = '0;
  bit          expReady;

  always @(negedge clk) begin
    if (chkEn) begin
      if (mBusy) mCount--;
      expReady = mBusy && (mCount == 0);
      check("ready", 64'(bus.ready), 64'(expReady));
      check("stall", 64'(bus.stall), 64'(bus.start && !expReady));
      check("result", bus.result, expReady ? mExp : mLast);
      if (bus.ready) readyCount++;
      if (rst) begin
        mBusy = 1'b0;
        mLast = '0;
      end else begin
        if (expReady) mLast = mExp;
        if (bus.annul || expReady) begin
          mBusy = 1'b0;
        end else if (!mBusy && bus.start) begin
          mBusy  = 1'b1;
          mExp   = refDiv(bus.opdata1, bus.opdata2, bus.signed_div);
          mCount = (bus.opdata2 == 32'd0) ? 2 : W + 1;
        end
      end
    end
  end

  // Start a divide at the next cycle (t0) and wait for ready; start stays high afterwards.
  task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int expLat, input logic [63:0] expRes, input string nm);
    int k = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opdata1 = a; bus.opdata2 = b; bus.signed_div = sgn;
    check({nm, " model"}, refDiv(a, b, sgn), expRes);
    while (!done) begin
      @(negedge clk);
      if (k == 0) check({nm, " stall t0"}, 64'(bus.stall), 64'd1);
      if (bus.ready) begin
        done = 1'b1;
        check({nm, " latency"}, 64'(k), 64'(expLat));
        check({nm, " value"}, bus.result, expRes);
      end else if (k >= 100) begin
        done = 1'b1;
        check({nm, " timeout"}, 64'(k), 64'(expLat));
      end else begin
        k++;
        @(posedge clk); #1;
      end
    end
    $display("div %s %h/%h signed=%0d -> %h at t%0d", nm, a, b, sgn, bus.result, k);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.annul = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saved;
    rst = 1'b1;
    bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
    bus.opdata1 = '0; bus.opdata2 = '0;
    @(posedge clk); #1;
    chkEn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset result", bus.result, 64'd0);
    check("reset ready", 64'(bus.ready), 64'd0);

    runDiv(32'd7, 32'd2, 1'b0, 33, {32'd1, 32'd3}, "divu 7/2");
    idle(1);
    runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div -7/2");
    idle(1);
    runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 33, {32'd1, 32'hFFFF_FFFD}, "div 7/-2");
    idle(1);
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'd0, 32'h8000_0000}, "div ovf");
    idle(1);
    runDiv(32'hFFFF_FFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFF_FFFF}, "divu max/1");
    idle(1);
    runDiv(32'd5, 32'd0, 1'b0, 2, {32'd5, 32'hFFFF_FFFF}, "divu 5/0");
    idle(1);
    runDiv(32'hFFFF_FFFB, 32'd0, 1'b1, 2, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "div -5/0");
    idle(2);
    runDiv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, {32'd0, 32'd1}, "divu max/max");
    idle(1);
    runDiv(32'd3, 32'd7, 1'b0, 33, {32'd3, 32'd0}, "divu 3/7");
    idle(1);
    runDiv(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 33, {32'hFFFF_FFFE, 32'd2}, "div -8/-3");
    idle(1);
    runDiv(32'h1234_5678, 32'h0000_1000, 1'b0, 33, {32'h0000_0678, 32'h0001_2345}, "divu hex");
    idle(1);

    // Annul at t10 of 100/3, restart at t12.
    saved = readyCount;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opdata1 = 32'd100; bus.opdata2 = 32'd3; bus.signed_div = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    bus.annul = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul no ready", 64'(readyCount), 64'(saved));
    $display("annul of 100/3 at t10");
    runDiv(32'd100, 32'd3, 1'b0, 33, {32'd1, 32'h21}, "divu 100/3 after annul");
    idle(1);

    // Annul together with start in IDLE: nothing accepted.
    saved = readyCount;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd5; bus.opdata2 = 32'd1;
    idle(40);
    @(negedge clk);
    check("annul idle no ready", 64'(readyCount), 64'(saved));
    $display("annul with start in IDLE");

    // Back-to-back with start held high.
    runDiv(32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, "b2b 9/3");
    runDiv(32'd10, 32'd4, 1'b0, 33, {32'd2, 32'd2}, "b2b 10/4");
    idle(1);

    // Reset mid-BUSY.
    saved = readyCount;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opdata1 = 32'd9; bus.opdata2 = 32'd3; bus.signed_div = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(40);
    @(negedge clk);
    check("rst no ready", 64'(readyCount), 64'(saved));
    check("rst result", bus.result, 64'd0);
    $display("reset during BUSY of 9/3");

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
